// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between an ALU (A) and a load (B) writeback source.
// Each source has a one-entry holding register; a round-robin arbiter issues one write per cycle.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              WE_Reg,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD_Reg,
  output logic              addr_err,
  output logic              busy
);

  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  logic              a_full_q, a_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_full_q, b_full_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              addr_err_q, addr_err_d;

  logic a_grant, b_grant;
  logic a_acc, b_acc;
  logic a_bad, b_bad;

  // Grant depends only on registered state, so ready never depends on valid.
  assign a_grant = a_full_q && (!b_full_q || (last_grant_q == SRC_B));
  assign b_grant = b_full_q && (!a_full_q || (last_grant_q == SRC_A));

  assign a_ready = !rst && (!a_full_q || a_grant);
  assign b_ready = !rst && (!b_full_q || b_grant);

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;
  assign a_bad = {1'b0, a_addr} >= CMP_W'(NUM_REGS);
  assign b_bad = {1'b0, b_addr} >= CMP_W'(NUM_REGS);

  // Next-state: holding registers, arbitration result and error flag.
  always_comb begin
    a_full_d     = a_full_q && !a_grant;
    a_addr_d     = a_addr_q;
    a_data_d     = a_data_q;
    b_full_d     = b_full_q && !b_grant;
    b_addr_d     = b_addr_q;
    b_data_d     = b_data_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    a3_d         = a3_q;
    wd_d         = wd_q;
    addr_err_d   = (a_acc && a_bad) || (b_acc && b_bad);

    if (a_acc && !a_bad) begin
      a_full_d = 1'b1;
      a_addr_d = a_addr;
      a_data_d = a_data;
    end
    if (b_acc && !b_bad) begin
      b_full_d = 1'b1;
      b_addr_d = b_addr;
      b_data_d = b_data;
    end

    if (a_grant) begin
      we_d         = 1'b1;
      a3_d         = a_addr_q;
      wd_d         = a_data_q;
      last_grant_d = SRC_A;
    end else if (b_grant) begin
      we_d         = 1'b1;
      a3_d         = b_addr_q;
      wd_d         = b_data_q;
      last_grant_d = SRC_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full_q     <= 1'b0;
      a_addr_q     <= '0;
      a_data_q     <= '0;
      b_full_q     <= 1'b0;
      b_addr_q     <= '0;
      b_data_q     <= '0;
      last_grant_q <= SRC_B;
      we_q         <= 1'b0;
      a3_q         <= '0;
      wd_q         <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      a_full_q     <= a_full_d;
      a_addr_q     <= a_addr_d;
      a_data_q     <= a_data_d;
      b_full_q     <= b_full_d;
      b_addr_q     <= b_addr_d;
      b_data_q     <= b_data_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      a3_q         <= a3_d;
      wd_q         <= wd_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign WE_Reg   = we_q;
  assign A3       = a3_q;
  assign WD_Reg   = wd_q;
  assign addr_err = addr_err_q;
  assign busy     = a_full_q | b_full_q | we_q;

endmodule
